instr_sequencer: RTL and testbench

Instruction fetch and issue sequencer for the 4-bit CPU. Reads 8-bit instruction words from program ROM over a request/acknowledge handshake and holds the program counter. Presents the opcode nibble `Op` and the execute strobe `Bit` to the instruction decode logic, and consumes the decoder's `Jump` output to fetch and apply a second-byte branch target. It sits between program memory and the decoder, producing exactly the `Op`/`Bit` pair the decoder consumes.

---
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer: fetches ROM bytes, strobes Op/Bit to the decoder, applies branch targets.
// Optional single-step mode: define INSTR_SEQ_STEP_EN to add the Step input and the STEPWAIT state.
module instr_sequencer #(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                Run,
  output logic                RomReq,
  output logic [PC_WIDTH-1:0] RomAddr,
  input  logic                RomAck,
  input  logic [7:0]          RomData,
  output logic [3:0]          Op,
  output logic [3:0]          Operand,
  output logic                Bit,
  input  logic                Jump,
  input  logic                Taken,
  output logic [PC_WIDTH-1:0] Pc,
  output logic                Halted
`ifdef INSTR_SEQ_STEP_EN
  ,
  input  logic                Step
`endif
);

  localparam int unsigned IR_WIDTH = 8;

  if (PC_WIDTH < 8 || PC_WIDTH > 12) begin : g_pc_width_check
    $error("instr_sequencer: PC_WIDTH must be in 8..12");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    ISSUE    = 3'd2,
    TARGET   = 3'd3,
    STEPWAIT = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  state_t                resume_state;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [IR_WIDTH-1:0]   ir_q;
  logic [IR_WIDTH-1:0]   ir_d;
  logic                  taken_q;
  logic                  taken_d;

  // Where an instruction lands once it has fully completed.
  always_comb begin
    resume_state = IDLE;
    if (Run) begin
`ifdef INSTR_SEQ_STEP_EN
      resume_state = STEPWAIT;
`else
      resume_state = FETCH;
`endif
    end
  end

  // Next-state and next-datapath values; ROM acks only matter in the requesting states.
  always_comb begin
    state_d = state_q;
    pc_d    = Pc;
    ir_d    = ir_q;
    taken_d = taken_q;
    case (state_q)
      IDLE: begin
        if (Run) state_d = FETCH;
      end
      FETCH: begin
        if (RomAck) begin
          ir_d    = RomData;
          pc_d    = Pc + PC_WIDTH'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        taken_d = Taken;
        state_d = Jump ? TARGET : resume_state;
      end
      TARGET: begin
        if (RomAck) begin
          pc_d    = taken_q ? PC_WIDTH'(RomData) : Pc + PC_WIDTH'(1);
          state_d = resume_state;
        end
      end
`ifdef INSTR_SEQ_STEP_EN
      STEPWAIT: begin
        if (!Run)      state_d = IDLE;
        else if (Step) state_d = FETCH;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered and valid for the whole state.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      Pc      <= PC_WIDTH'(RESET_PC);
      ir_q    <= '0;
      taken_q <= 1'b0;
      RomReq  <= 1'b0;
      RomAddr <= PC_WIDTH'(RESET_PC);
      Bit     <= 1'b0;
      Halted  <= 1'b1;
    end else begin
      state_q <= state_d;
      Pc      <= pc_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
      RomReq  <= (state_d == FETCH) || (state_d == TARGET);
      RomAddr <= pc_d;
      Bit     <= (state_d == ISSUE);
      Halted  <= (state_d == IDLE);
    end
  end

  assign Op      = ir_q[7:4];
  assign Operand = ir_q[3:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: cycle vector table plus directed multi-cycle sequences.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       rom_req;
  logic [7:0] rom_addr;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [3:0] op;
  logic [3:0] operand;
  logic       strobe;
  logic       jump;
  logic       taken;
  logic [7:0] pc;
  logic       halted;
`ifdef INSTR_SEQ_STEP_EN
  logic       step;
`endif

  logic [7:0] rom [256];
  int         rom_wait;
  int         wait_cnt;
  int         total;
  int         bad;

  instr_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
    .Clock   (clk),
    .nReset  (rst_n),
    .Run     (run),
    .RomReq  (rom_req),
    .RomAddr (rom_addr),
    .RomAck  (rom_ack),
    .RomData (rom_data),
    .Op      (op),
    .Operand (operand),
    .Bit     (strobe),
    .Jump    (jump),
    .Taken   (taken),
    .Pc      (pc),
    .Halted  (halted)
`ifdef INSTR_SEQ_STEP_EN
    ,
    .Step    (step)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder model: opcode 0xC is the only branch.
  assign jump = (op == 4'hC);

  // ROM model: acks after rom_wait request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= 0;
    else if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end
  assign rom_ack  = rom_req && (wait_cnt >= rom_wait);
  assign rom_data = rom[rom_addr];

  typedef struct {
    logic       run;
    logic       taken;
    logic       req;
    logic [7:0] addr;
    logic       stb;
    logic [3:0] op;
    logic [3:0] opd;
    logic [7:0] pc;
    logic       halted;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bits;
    total    = 0;
    bad      = 0;
    rom_wait = 0;
    run      = 1'b0;
    taken    = 1'b0;
    rst_n    = 1'b0;
`ifdef INSTR_SEQ_STEP_EN
    step     = 1'b0;
`endif
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h41; rom[8'h01] = 8'h62; rom[8'h02] = 8'h93;
    rom[8'h03] = 8'hC0; rom[8'h04] = 8'h20; rom[8'h20] = 8'h57;
    rom[8'h21] = 8'hC3; rom[8'h22] = 8'h80; rom[8'h23] = 8'h1F;
    rom[8'h24] = 8'h35; rom[8'h25] = 8'hC1; rom[8'h26] = 8'hFF;
    rom[8'hFF] = 8'h72;

    //          run   taken  req   addr   stb   op    opd   pc     halted
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 4'h4, 4'h1, 8'h01, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 4'h4, 4'h1, 8'h01, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 4'h6, 4'h2, 8'h02, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 4'h6, 4'h2, 8'h02, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 4'h9, 4'h3, 8'h03, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 4'h9, 4'h3, 8'h03, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 4'hC, 4'h0, 8'h04, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 4'hC, 4'h0, 8'h04, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 4'hC, 4'h0, 8'h20, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h21, 1'b1, 4'h5, 4'h7, 8'h21, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h21, 1'b0, 4'h5, 4'h7, 8'h21, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h21, 1'b0, 4'h5, 4'h7, 8'h21, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 4'hC, 4'h3, 8'h22, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 4'hC, 4'h3, 8'h22, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 8'h23, 1'b0, 4'hC, 4'h3, 8'h23, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h24, 1'b1, 4'h1, 4'hF, 8'h24, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h24, 1'b0, 4'h1, 4'hF, 8'h24, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 8'h24, 1'b0, 4'h1, 4'hF, 8'h24, 1'b1};

    // Reset values while held in reset
    cyc(); cyc();
    check("reset_vals", 32'({rom_req, rom_addr, strobe, op, operand, pc, halted}),
          32'({1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1}));
    rst_n = 1'b1;

`ifndef INSTR_SEQ_STEP_EN
    // Linear fetch, taken jump, run drop at ISSUE, not-taken jump
    for (int i = 0; i < 20; i++) begin
      cyc();
      check($sformatf("vec%0d", i),
            32'({rom_req, rom_addr, strobe, op, operand, pc, halted}),
            32'({vecs[i].req, vecs[i].addr, vecs[i].stb, vecs[i].op, vecs[i].opd,
                 vecs[i].pc, vecs[i].halted}));
      run   = vecs[i].run;
      taken = vecs[i].taken;
    end

    // Wait states with Run dropped during the pending fetch
    rom_wait = 3;
    run      = 1'b1;
    cyc();
    run = 1'b0;
    n   = 0;
    while (rom_req && n < 10) begin
      check("wait_addr_hold", 32'({rom_addr, strobe}), 32'({8'h24, 1'b0}));
      n++;
      cyc();
    end
    check("wait_req_cycles", 32'(n), 32'd4);
    check("wait_issue", 32'({strobe, op, operand, pc}), 32'({1'b1, 4'h3, 4'h5, 8'h25}));
    cyc();
    check("run_drop_idle", 32'({halted, strobe, rom_req}), 32'({1'b1, 1'b0, 1'b0}));
    cyc();
    check("idle_hold", 32'({halted, strobe, rom_req, pc}), 32'({1'b1, 1'b0, 1'b0, 8'h25}));

    // Taken jump to 0xFF, then a non-jump there wraps Pc to 0
    rom_wait = 0;
    run      = 1'b1;
    taken    = 1'b1;
    cyc();
    cyc();
    check("wrap_jump_issue", 32'({strobe, op}), 32'({1'b1, 4'hC}));
    cyc();
    taken = 1'b0;
    check("wrap_target_addr", 32'({rom_req, rom_addr}), 32'({1'b1, 8'h26}));
    cyc();
    run = 1'b0;
    check("wrap_fetch_ff", 32'({rom_req, rom_addr, pc}), 32'({1'b1, 8'hFF, 8'hFF}));
    cyc();
    check("wrap_issue", 32'({strobe, op, operand, pc}), 32'({1'b1, 4'h7, 4'h2, 8'h00}));
    cyc();
    check("wrap_idle", 32'({halted, pc, rom_addr}), 32'({1'b1, 8'h00, 8'h00}));

    // Reach a stuck fetch at a nonzero Pc
    run = 1'b1;
    cyc();
    cyc();
    rom_wait = 7;
    cyc();
`else
    // Single-step: no Bit without Step, exactly one Bit per Step pulse
    run = 1'b1;
    cyc();
    cyc();
    check("step_first_issue", 32'({strobe, op, operand}), 32'({1'b1, 4'h4, 4'h1}));
    cyc();
    check("stepwait_hold", 32'({rom_req, halted, strobe}), 32'({1'b0, 1'b0, 1'b0}));
    bits = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (strobe) bits++;
    end
    check("no_step_no_bit", 32'(bits), 32'd0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    bits = 0;
    for (int i = 0; i < 6; i++) begin
      if (strobe) bits++;
      cyc();
    end
    check("one_step_one_bit", 32'(bits), 32'd1);
    check("step_state", 32'({op, operand, pc, halted}), 32'({4'h6, 4'h2, 8'h02, 1'b0}));
    rom_wait = 7;
    step     = 1'b1;
    cyc();
    step = 1'b0;
`endif

    // Asynchronous reset in the middle of an open request
    check("pre_reset_req", 32'({rom_req, halted}), 32'({1'b1, 1'b0}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({rom_req, rom_addr, strobe, op, operand, pc, halted}),
          32'({1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1}));
    run = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_reset_idle", 32'({rom_req, halted, pc}), 32'({1'b0, 1'b1, 8'h00}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
